// File: rtl/host_cmd_decoder.sv
// Frames the SPI host byte stream into fixed-length command packets and
// presents one decoded command per packet on a valid/ready interface.
module host_cmd_decoder #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [7:0]  in_data,
  input  logic        in_vld,
  output logic        in_rdy,
  output logic        cmd_vld,
  input  logic        cmd_rdy,
  output logic [2:0]  cmd_op,
  output logic [15:0] cmd_addr,
  output logic [15:0] cmd_data,
  output logic        err_pulse,
  output logic [7:0]  err_count
);

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_FIRE   = 8'h01;
  localparam logic [7:0] OP_STEP   = 8'h02;
  localparam logic [7:0] OP_CLEAR  = 8'h03;
  localparam logic [7:0] OP_CONFIG = 8'h04;

  typedef enum logic [1:0] {IDLE, PAYLOAD, HOLD} state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [2:0]  remaining;
  logic [31:0] shift;
  logic [31:0] shift_nxt;
  logic [15:0] stall;
  logic        accept;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Flush and reset both block the byte offered in the same cycle.
  assign in_rdy    = (state != HOLD) & ~reset & ~flush;
  assign accept    = in_vld & in_rdy;
  assign shift_nxt = {shift[23:0], in_data};

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state     <= IDLE;
      op_q      <= 3'd0;
      remaining <= 3'd0;
      shift     <= 32'd0;
      stall     <= 16'd0;
      cmd_vld   <= 1'b0;
      cmd_op    <= 3'd0;
      cmd_addr  <= 16'd0;
      cmd_data  <= 16'd0;
      err_pulse <= 1'b0;
      if (reset)
        err_count <= 8'd0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shift <= 32'd0;
            stall <= 16'd0;
            case (in_data)
              OP_NOP: ;
              OP_FIRE: begin
                op_q      <= 3'd1;
                remaining <= 3'd3;
                state     <= PAYLOAD;
              end
              OP_STEP: begin
                op_q      <= 3'd2;
                remaining <= 3'd2;
                state     <= PAYLOAD;
              end
              OP_CLEAR: begin
                cmd_op   <= 3'd3;
                cmd_addr <= 16'd0;
                cmd_data <= 16'd0;
                cmd_vld  <= 1'b1;
                state    <= HOLD;
              end
              OP_CONFIG: begin
                op_q      <= 3'd4;
                remaining <= 3'd4;
                state     <= PAYLOAD;
              end
              default: begin
                err_pulse <= 1'b1;
                err_count <= sat_inc(err_count);
              end
            endcase
          end
        end
        PAYLOAD: begin
          if (accept) begin
            shift     <= shift_nxt;
            stall     <= 16'd0;
            remaining <= remaining - 3'd1;
            if (remaining == 3'd1) begin
              cmd_op  <= op_q;
              cmd_vld <= 1'b1;
              state   <= HOLD;
              // Fields are pulled from the byte-aligned tail of the shift register.
              case (op_q)
                3'd1: begin
                  cmd_addr <= shift_nxt[23:8];
                  cmd_data <= {8'h00, shift_nxt[7:0]};
                end
                3'd2: begin
                  cmd_addr <= 16'd0;
                  cmd_data <= shift_nxt[15:0];
                end
                default: begin
                  cmd_addr <= shift_nxt[31:16];
                  cmd_data <= shift_nxt[15:0];
                end
              endcase
            end
          end else if (TIMEOUT != 16'd0 && stall == TIMEOUT - 16'd1) begin
            stall     <= 16'd0;
            state     <= IDLE;
            err_pulse <= 1'b1;
            err_count <= sat_inc(err_count);
          end else begin
            stall <= stall + 16'd1;
          end
        end
        HOLD: begin
          if (cmd_rdy) begin
            cmd_vld <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_cmd_decoder.sv
// Directed bench for host_cmd_decoder: packet framing, hold, errors,
// timeout, flush, error-count saturation and reset.
module tb_host_cmd_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic        cmd_vld;
  logic        cmd_rdy = 1'b1;
  logic [2:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [15:0] cmd_data;
  logic        err_pulse;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  logic [34:0] q[$];

  host_cmd_decoder #(.TIMEOUT(16'd8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Record accepted commands and error pulses mid-cycle.
  always @(negedge clk) begin
    if (!reset && cmd_vld && cmd_rdy) q.push_back({cmd_op, cmd_addr, cmd_data});
    if (!reset && err_pulse) err_seen++;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data = b;
    in_vld  = 1'b1;
    while (!in_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL send_timeout: byte %02h not accepted within 50 cycles", b);
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL reset_in_rdy: got %b want 0", in_rdy); end
    checks++; if (cmd_vld !== 1'b0) begin failures++; $display("FAIL reset_cmd_vld: got %b want 0", cmd_vld); end
    checks++; if ({cmd_op, cmd_addr, cmd_data} !== 35'd0) begin failures++;
      $display("FAIL reset_fields: got op=%0d addr=%04h data=%04h want 0", cmd_op, cmd_addr, cmd_data); end
    checks++; if (err_count !== 8'd0 || err_pulse !== 1'b0) begin failures++;
      $display("FAIL reset_err: got cnt=%0d pulse=%b want 0/0", err_count, err_pulse); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL reset_release_rdy: got %b want 1", in_rdy); end
  endtask

  task automatic test_input_fire;
    q.delete();
    cmd_rdy = 1'b1;
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    checks++; if (cmd_vld !== 1'b0) begin failures++; $display("FAIL fire_early: cmd_vld=%b want 0", cmd_vld); end
    send_byte(8'h56);
    checks++; if (cmd_vld !== 1'b1) begin failures++; $display("FAIL fire_latency: cmd_vld=%b want 1", cmd_vld); end
    idle(1);
    checks++; if (cmd_vld !== 1'b0) begin failures++; $display("FAIL fire_width: cmd_vld=%b want 0", cmd_vld); end
    idle(2);
    checks++; if (q.size() != 1) begin failures++; $display("FAIL fire_count: got %0d want 1", q.size()); end
    checks++; if (q[0] !== {3'd1, 16'h1234, 16'h0056}) begin failures++;
      $display("FAIL fire_fields: got %09h want %09h", q[0], {3'd1, 16'h1234, 16'h0056}); end
  endtask

  task automatic test_hold;
    logic stable = 1'b1;
    logic blocked = 1'b1;
    q.delete();
    cmd_rdy = 1'b0;
    send_byte(8'h04); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'h12); send_byte(8'h34);
    in_data = 8'h02;
    in_vld  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (cmd_vld !== 1'b1 || {cmd_op, cmd_addr, cmd_data} !== {3'd4, 16'hABCD, 16'h1234}) stable = 1'b0;
      if (in_rdy !== 1'b0) blocked = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin failures++;
      $display("FAIL hold_stable: op=%0d addr=%04h data=%04h vld=%b want 4/ABCD/1234/1", cmd_op, cmd_addr, cmd_data, cmd_vld); end
    checks++; if (blocked !== 1'b1) begin failures++; $display("FAIL hold_in_rdy: in_rdy=%b want 0", in_rdy); end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL hold_premature: got %0d cmds want 0", q.size()); end
    @(posedge clk); #1;
    cmd_rdy = 1'b1;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h05);
    idle(3);
    checks++; if (q.size() != 2) begin failures++; $display("FAIL hold_count: got %0d want 2", q.size()); end
    if (q.size() >= 2) begin
      checks++; if (q[0] !== {3'd4, 16'hABCD, 16'h1234}) begin failures++;
        $display("FAIL hold_cfg: got %09h want %09h", q[0], {3'd4, 16'hABCD, 16'h1234}); end
      checks++; if (q[1] !== {3'd2, 16'h0000, 16'h0005}) begin failures++;
        $display("FAIL hold_step: got %09h want %09h", q[1], {3'd2, 16'h0000, 16'h0005}); end
    end
  endtask

  task automatic test_unknown;
    int e0;
    q.delete();
    e0 = err_seen;
    send_byte(8'h7F); send_byte(8'h03);
    idle(3);
    checks++; if (err_seen - e0 != 1) begin failures++; $display("FAIL unk_pulse: got %0d pulses want 1", err_seen - e0); end
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL unk_count: got %0d want 1", err_count); end
    checks++; if (q.size() != 1 || q[0] !== {3'd3, 16'h0, 16'h0}) begin failures++;
      $display("FAIL unk_clear: got n=%0d first=%09h want 1 x %09h", q.size(), q[0], {3'd3, 16'h0, 16'h0}); end
  endtask

  task automatic test_timeout;
    int e0;
    q.delete();
    e0 = err_seen;
    send_byte(8'h02); send_byte(8'h00);
    idle(7);
    checks++; if (err_seen - e0 != 0) begin failures++; $display("FAIL tmo_early: got %0d pulses want 0", err_seen - e0); end
    idle(4);
    checks++; if (err_seen - e0 != 1) begin failures++; $display("FAIL tmo_pulse: got %0d pulses want 1", err_seen - e0); end
    checks++; if (err_count !== 8'd2) begin failures++; $display("FAIL tmo_count: got %0d want 2", err_count); end
    checks++; if (q.size() != 0) begin failures++; $display("FAIL tmo_nocmd: got %0d cmds want 0", q.size()); end
    send_byte(8'h03);
    idle(3);
    checks++; if (q.size() != 1 || q[0] !== {3'd3, 16'h0, 16'h0}) begin failures++;
      $display("FAIL tmo_clear: got n=%0d first=%09h want 1 x %09h", q.size(), q[0], {3'd3, 16'h0, 16'h0}); end
  endtask

  task automatic test_flush;
    int e0;
    q.delete();
    e0 = err_seen;
    send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
    flush   = 1'b1;
    in_data = 8'h33;
    in_vld  = 1'b1;
    #1;
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL flush_rdy: got %b want 0", in_rdy); end
    @(posedge clk); #1;
    flush  = 1'b0;
    in_vld = 1'b0;
    send_byte(8'h00); send_byte(8'h03);
    idle(3);
    checks++; if (q.size() != 1 || q[0] !== {3'd3, 16'h0, 16'h0}) begin failures++;
      $display("FAIL flush_cmds: got n=%0d first=%09h want 1 x %09h", q.size(), q[0], {3'd3, 16'h0, 16'h0}); end
    checks++; if (err_count !== 8'd2 || err_seen != e0) begin failures++;
      $display("FAIL flush_err: got cnt=%0d pulses=%0d want 2/0", err_count, err_seen - e0); end
  endtask

  task automatic test_back_to_back;
    q.delete();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
    idle(3);
    checks++; if (q.size() != 2) begin failures++; $display("FAIL b2b_count: got %0d want 2", q.size()); end
    if (q.size() >= 2) begin
      checks++; if (q[0] !== {3'd2, 16'h0000, 16'h0000}) begin failures++;
        $display("FAIL b2b_step0: got %09h want %09h", q[0], {3'd2, 16'h0000, 16'h0000}); end
      checks++; if (q[1] !== {3'd1, 16'hFFFF, 16'h00FF}) begin failures++;
        $display("FAIL b2b_fire: got %09h want %09h", q[1], {3'd1, 16'hFFFF, 16'h00FF}); end
    end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 300; i++) send_byte(8'hEE);
    idle(2);
    checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL sat_count: got %0d want 255", err_count); end
    reset = 1'b1;
    #1;
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL sat_reset_rdy: got %b want 0", in_rdy); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL sat_reset_cnt: got %0d want 0", err_count); end
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL sat_after_rdy: got %b want 1", in_rdy); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_input_fire();
    test_hold();
    test_unknown();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
